// File: rtl/shift_right_iter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : shift_right_iter_pkg                                   |
// | Description : Shared types and constants for the iterative right     |
// |               shifter (state encoding, op codes, default sizes).     |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package shift_right_iter_pkg;

  localparam int DEF_WIDTH   = 32;
  localparam int DEF_SHAMT_W = 5;

  // Fill selection captured with start
  localparam logic SHR_LOGIC = 1'b0;
  localparam logic SHR_ARITH = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

endpackage
`default_nettype wire

// File: rtl/shift_right_iter_shr_step.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : shift_right_iter_shr_step                              |
// | Description : One binary-weighted stage of the right shifter: shifts |
// |               acc right by 2^step with the given fill bit, or passes |
// |               acc through unchanged when en is low.                  |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module shift_right_iter_shr_step
  import shift_right_iter_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int SHAMT_W = DEF_SHAMT_W,
  parameter int STEP_W  = 3
) (
  input  logic [WIDTH-1:0]  acc,
  input  logic [STEP_W-1:0] step,
  input  logic              en,
  input  logic              fill,
  output logic [WIDTH-1:0]  acc_out
);

  logic        [SHAMT_W-1:0] w_dist;
  logic signed [WIDTH:0]     w_ext;

  // Prepend the fill bit as a sign bit so >>> replicates it into the vacated bits
  always_comb begin
    w_dist       = '0;
    w_dist[step] = 1'b1;
    w_ext        = {fill, acc};
    acc_out      = en ? WIDTH'(w_ext >>> w_dist) : acc;
  end

endmodule
`default_nettype wire

// File: rtl/shift_right_iter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : shift_right_iter                                       |
// | Description : Multi-cycle logical/arithmetic right shifter. Resolves |
// |               one binary-weighted stage of the shift amount per      |
// |               clock behind a start/ready/done handshake.             |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module shift_right_iter
  import shift_right_iter_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int SHAMT_W = DEF_SHAMT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             arith,
  input  logic [WIDTH-1:0] operand,
  input  logic [31:0]      sa,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int STEP_W = (SHAMT_W > 1) ? $clog2(SHAMT_W) : 1;
  localparam logic [STEP_W-1:0] C_LAST_STEP = STEP_W'(SHAMT_W - 1);

  state_t             r_state;
  logic [WIDTH-1:0]   r_acc;
  logic [SHAMT_W-1:0] r_amt;
  logic               r_fill;
  logic [STEP_W-1:0]  r_step;
  logic               r_ready;
  logic               r_busy;
  logic               r_done;
  logic [WIDTH-1:0]   r_result;

  logic [WIDTH-1:0]   w_acc_next;
  logic               w_fill_in;
  logic               w_unused_sa;

  // Only the low SHAMT_W bits of the shift amount are meaningful
  assign w_unused_sa = ^sa[31:SHAMT_W];
  assign w_fill_in   = (arith == SHR_ARITH) & operand[WIDTH-1];

  shift_right_iter_shr_step #(
    .WIDTH   (WIDTH),
    .SHAMT_W (SHAMT_W),
    .STEP_W  (STEP_W)
  ) u_shr_step (
    .acc     (r_acc),
    .step    (r_step),
    .en      (r_amt[r_step]),
    .fill    (r_fill),
    .acc_out (w_acc_next)
  );

  // Control FSM with registered handshake outputs; result only moves on SHIFT->DONE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_acc    <= '0;
      r_amt    <= '0;
      r_fill   <= 1'b0;
      r_step   <= '0;
      r_ready  <= 1'b1;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_result <= '0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          r_done <= 1'b0;
          if (start) begin
            r_acc   <= operand;
            r_amt   <= sa[SHAMT_W-1:0];
            r_fill  <= w_fill_in;
            r_step  <= '0;
            r_state <= SHIFT;
            r_ready <= 1'b0;
            r_busy  <= 1'b1;
          end else begin
            r_state <= IDLE;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
          end
        end
        SHIFT: begin
          r_acc  <= w_acc_next;
          r_step <= r_step + 1'b1;
          if (r_step == C_LAST_STEP) begin
            r_result <= w_acc_next;
            r_state  <= DONE;
            r_ready  <= 1'b1;
            r_busy   <= 1'b0;
            r_done   <= 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_ready <= 1'b1;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign ready  = r_ready;
  assign busy   = r_busy;
  assign done   = r_done;
  assign result = r_result;

endmodule
`default_nettype wire

// File: tb/tb_shift_right_iter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_shift_right_iter                                    |
// | Description : Scoreboard bench for shift_right_iter: stimulus pushes |
// |               expected result and done cycle, a monitor pops on done.|
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_shift_right_iter;

  typedef struct {
    logic [31:0] res;
    int          cyc;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        start;
  logic        arith;
  logic [31:0] operand;
  logic [31:0] sa;
  logic        ready;
  logic        busy;
  logic        done;
  logic [31:0] result;

  exp_t exp_q[$];
  int   cyc;
  int   n_total;
  int   n_pass;

  shift_right_iter #(
    .WIDTH   (32),
    .SHAMT_W (5)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .arith   (arith),
    .operand (operand),
    .sa      (sa),
    .ready   (ready),
    .busy    (busy),
    .done    (done),
    .result  (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edge counter used to check done latency
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_total++;
    if (act !== expv)
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, expv, $time);
    else
      n_pass++;
  endtask

  task automatic next_edge(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: pops one expectation per done pulse
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (done) begin
        if (exp_q.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_done: got done=1 expected no pending request (t=%0t)", $time);
        end else begin
          e = exp_q.pop_front();
          chk("result", result, e.res);
          chk("done_cycle", 32'(cyc), 32'(e.cyc));
          chk("ready_in_done", {31'd0, ready}, 32'd1);
        end
      end
    end
  end

  // Issue one request; assumes called at posedge+1
  task automatic issue(input logic [31:0] op, input logic [31:0] s, input logic ar,
                       input logic [31:0] expv);
    int guard;
    guard = 0;
    while (!ready && guard < 100) begin
      next_edge(1);
      guard++;
    end
    if (!ready) begin
      n_total++;
      $display("FAIL ready_timeout: got ready=0 expected ready=1");
    end
    start   = 1'b1;
    operand = op;
    sa      = s;
    arith   = ar;
    exp_q.push_back('{res: expv, cyc: cyc + 6});
    next_edge(1);
    start   = 1'b0;
    operand = 32'hA5A5_5A5A;
    sa      = 32'h0000_001F;
    arith   = 1'b1;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (exp_q.size() != 0 && guard < 50) begin
      next_edge(1);
      guard++;
    end
    if (exp_q.size() != 0) begin
      n_total++;
      $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
      exp_q.delete();
    end
    next_edge(2);
  endtask

  initial begin
    cyc     = 0;
    n_total = 0;
    n_pass  = 0;
    rst     = 1'b1;
    start   = 1'b0;
    arith   = 1'b0;
    operand = '0;
    sa      = '0;
    next_edge(2);
    chk("rst_ready", {31'd0, ready}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_result", result, 32'd0);
    rst = 1'b0;
    next_edge(2);

    // Basic logical / arithmetic cases
    issue(32'h0F0F_F0C3, 32'd4, 1'b0, 32'h00F0_FF0C);
    chk("busy_during_shift", {31'd0, busy}, 32'd1);
    drain();
    issue(32'hF0F0_0F3C, 32'd8, 1'b1, 32'hFFF0_F00F); drain();
    issue(32'hF0F0_0F3C, 32'd8, 1'b0, 32'h00F0_F00F); drain();
    issue(32'h7FFF_0000, 32'd16, 1'b1, 32'h0000_7FFF); drain();

    // Boundary amounts and ignored upper sa bits
    issue(32'h8000_0000, 32'd31, 1'b1, 32'hFFFF_FFFF); drain();
    issue(32'h8000_0000, 32'd31, 1'b0, 32'h0000_0001); drain();
    issue(32'hDEAD_BEEF, 32'd0, 1'b1, 32'hDEAD_BEEF); drain();
    issue(32'h0F0F_F0C3, 32'h0000_0024, 1'b0, 32'h00F0_FF0C); drain();

    // A start pulsed during SHIFT must be ignored
    issue(32'h1234_5678, 32'd12, 1'b0, 32'h0001_2345);
    next_edge(1);
    start = 1'b1; operand = 32'hFFFF_FFFF; sa = 32'd1; arith = 1'b1;
    next_edge(1);
    start = 1'b0;
    drain();

    // Back-to-back: start held through the DONE cycle
    start = 1'b1; operand = 32'h8000_0000; sa = 32'd31; arith = 1'b1;
    exp_q.push_back('{res: 32'hFFFF_FFFF, cyc: cyc + 6});
    exp_q.push_back('{res: 32'h00F0_FF0C, cyc: cyc + 12});
    next_edge(1);
    operand = 32'h0F0F_F0C3; sa = 32'h0000_0024; arith = 1'b0;
    next_edge(6);
    start = 1'b0;
    drain();

    // Asynchronous reset in the middle of a shift
    issue(32'hF0F0_0F3C, 32'd8, 1'b1, 32'hFFF0_F00F);
    next_edge(2);
    chk("result_hold", result, 32'h00F0_FF0C);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_ready", {31'd0, ready}, 32'd1);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_done", {31'd0, done}, 32'd0);
    chk("midrst_result", result, 32'd0);
    exp_q.delete();
    next_edge(2);
    rst = 1'b0;
    next_edge(10);
    issue(32'h8000_0000, 32'd31, 1'b0, 32'h0000_0001); drain();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/shift_right_iter.md
Name: shift_right_iter

Overview:
- Multi-cycle right shifter: the receiving-side counterpart of the combinational left-shift block. Performs logical (SRL/SRLV) and arithmetic (SRA/SRAV) right shifts.
- Decomposes the shift amount into binary-weighted stages and resolves one stage per clock.
- Sits beside the ALU in the execute stage. Uses a start/ready/done handshake so the pipeline controller can stall on it.

Parameters:
- WIDTH, 32, operand and result width in bits.
- SHAMT_W, 5, number of shift-amount bits used; must equal log2(WIDTH).

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only while ready=1.
- arith  input  1  1 = arithmetic (sign-fill), 0 = logical (zero-fill); captured with start.
- operand  input  WIDTH  value to shift; captured with start.
- sa  input  32  shift amount; only sa[SHAMT_W-1:0] is used, upper bits are ignored.
- ready  output  1  block can accept start.
- busy  output  1  shift in progress.
- done  output  1  one-cycle pulse: result is valid.
- result  output  WIDTH  shifted value; held until the next accepted start.

Behaviour:
- Clock and reset: one clock (clk); reset rst is asynchronous, active-high.
- Reset values: state=IDLE, ready=1, busy=0, done=0, result=0, and all internal registers 0. Reset takes effect immediately, including mid-operation. The in-flight shift is discarded and no done pulse is issued.
- States:
  - IDLE: ready=1, busy=0, done=0.
  - SHIFT: ready=0, busy=1, done=0.
  - DONE: ready=1, busy=0, done=1.
- Accept: on a clk edge with ready=1 and start=1:
  - Capture acc=operand, amt=sa[SHAMT_W-1:0], fill=arith&operand[WIDTH-1], step=0.
  - Go to SHIFT.
- SHIFT step: each edge, if amt[step]=1 then acc = acc shifted right by 2^step, with the vacated upper bits set to fill; otherwise acc is unchanged. Then step increments.
- Leaving SHIFT: at the edge processing step=SHAMT_W-1, write the final value to result and go to DONE.
- Latency: done is high in the cycle after the (SHAMT_W+1)-th edge counted from the accepting edge. The default is 6 edges. Latency is fixed and independent of the shift amount, including amt=0.
- DONE: done=1 for exactly one cycle.
  - start=1 on that edge accepts a new request (back-to-back); go to SHIFT.
  - Otherwise go to IDLE.
- start while busy=1: ignored. No queuing, no effect on the current operation.
- Input stability: operand, sa and arith are sampled only at the accepting edge. Changes afterwards do not affect the current result.
- result update: result changes only at the SHIFT→DONE edge and otherwise holds its value.
- Width rules:
  - amt is SHAMT_W bits wide, so the maximum shift is WIDTH-1.
  - amt=0 gives result=operand.
  - Arithmetic shift of a non-negative operand is identical to a logical shift.

Decomposition:
- Shared package holds:
  - State encoding: IDLE=2'b00, SHIFT=2'b01, DONE=2'b10.
  - Op constants: SHR_LOGIC=1'b0, SHR_ARITH=1'b1.
  - Default WIDTH and SHAMT_W.
- One sub-module is natural: shr_step, a combinational conditional right shift.
  - Inputs: acc, step index, enable bit, fill bit.
  - Output: acc>>2^step with fill, or acc unchanged when the enable bit is 0.
  - The FSM, step counter and registers stay in the top-level module.

Test Plan:
- Logical shift: operand=0x0F0FF0C3, sa=4, arith=0 -> done 6 edges after accept, result=0x00F0FF0C, ready=1 in the done cycle.
- Arithmetic shift: operand=0xF0F00F3C, sa=8, arith=1 -> result=0xFFF0F00F. Same input with arith=0 -> 0x00F0F00F.
- Boundary amounts:
  - operand=0x80000000, sa=31: arith=1 -> 0xFFFFFFFF; arith=0 -> 0x00000001.
  - sa=0 -> result=operand, still 6-edge latency.
- Upper sa bits ignored: sa=0x00000024 (low 5 bits = 4), operand=0x0F0FF0C3, arith=0 -> 0x00F0FF0C.
- Handshake: a second start pulsed during SHIFT is ignored and result is for the first request. start held in the DONE cycle is accepted back-to-back, with the next done 6 edges later.
- Reset mid-operation: assert rst 3 edges after accept -> ready=1, busy=0, done=0, result=0 immediately (asynchronously); no done pulse follows; the next start operates normally.
